typed_stream_fifo: RTL
======================

Name: typed_stream_fifo

Overview:
- Synchronous valid/ready FIFO whose element type is a type parameter, so one block covers scalar, packed-vector and packed-struct payloads.
- Generalises the single type-parameter comparison module to a depth-parametrised buffer with real handshake state.
- The elaboration-time type comparison is exported as a status output.
- Lives in the type-parameter regression suite. It is the standard stimulus for type-parameter propagation through storage, ports and type() equality.

Parameters:
- T, logic[7:0], element type stored and transported; any packed type.
- CHECK_T, T, reference type compared against T with type(T) == type(CHECK_T).
- DEPTH, 4, number of entries; power of two, >= 2.
- CW, $clog2(DEPTH+1), occupancy counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents in_data.
- in_ready  output  1  FIFO accepts this cycle; equals !full.
- in_data  input  $bits(T)  write payload, declared as type T.
- out_valid  output  1  out_data holds the head entry; equals !empty.
- out_ready  input  1  consumer takes the head this cycle.
- out_data  output  $bits(T)  head entry, declared as type T.
- count  output  CW  current occupancy, 0..DEPTH.
- type_match  output  1  constant: 1 when type(T) == type(CHECK_T), else 0.

Behaviour:
- Reset (rst=1 at a rising clk edge):
  - Write pointer, read pointer and count go to 0.
  - in_ready=1, out_valid=0, count=0.
  - Storage contents are not cleared; out_data is don't-care while out_valid=0.
  - type_match is unaffected because it is constant.
- Reset asserted mid-stream discards all entries in one cycle. rst has priority over push and pop in the same cycle.
- Push: in_valid && in_ready at the edge writes in_data to mem[wptr]; wptr increments.
- Pop: out_valid && out_ready at the edge increments rptr.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Full/empty is derived from count, not from pointer equality.
- Show-ahead read: out_data = mem[rptr] combinationally.
  - Latency from a push into an empty FIFO to out_valid=1 is exactly 1 cycle.
  - Push and pop never pass through in the same cycle while empty.
- Count update per edge:
  - push only: +1
  - pop only: -1
  - both, or neither: unchanged
- Full (count==DEPTH):
  - in_ready=0, so in_valid is ignored.
  - A simultaneous pop frees a slot that becomes visible next cycle; there is no same-cycle push-when-full.
- Empty (count==0):
  - out_valid=0, so out_ready is ignored.
  - count never underflows or overflows.
- Simultaneous push and pop at 0 < count < DEPTH: both pointers advance, count is held, and order is preserved.
- Payload is stored and returned bit-exact as type T; no width truncation or extension occurs anywhere.
- type_match is an elaboration-time constant from a type-equality expression, not a port comparison:
  - Differing widths → 0.
  - Differing signedness → 0.
  - Differing packed-struct identity → 0.
  - Identical type through a typedef alias → 1.
- Parameter checks at elaboration:
  - DEPTH not a power of two, or DEPTH < 2 → $error.
  - $bits(T) == 0 → $error.

Test Plan:
- Default types, DEPTH=4: reset, then push 8'hA1, 8'hB2, 8'hC3, 8'hD4 on consecutive cycles with out_ready=0.
  - count steps 1, 2, 3, 4; in_ready=0 after the 4th push.
  - A fifth push of 8'hEE is ignored.
  - Pops then return A1, B2, C3, D4.
- Full FIFO, one cycle with in_valid=1 (8'h55) and out_ready=1:
  - Pop of A1 only; count=3.
  - Next cycle in_ready=1 and the push of 8'h55 is accepted; 55 emerges last.
- Count=2, then 10 cycles of simultaneous push/pop with data 0..9:
  - count stays 2 throughout.
  - Output sequence is the two prior entries followed by 0..7.
  - Pointers wrap at least twice.
- Reset mid-stream: count=3, rst=1 for one cycle together with in_valid=1 and out_ready=1.
  - Next cycle count=0, out_valid=0, in_ready=1; the pushed word is not stored.
- Elaborate with T=logic[7:0] and CHECK_T=logic[7:0] via a typedef alias → type_match=1.
- Elaborate with T=logic[7:0] and CHECK_T=logic signed [7:0] → type_match=0.
- Elaborate with T=logic[15:0], CHECK_T=logic → type_match=0.
- Packed-struct T={logic[3:0] tag; logic[11:0] val}, DEPTH=8: 8 pushes then 8 pops → all struct fields match bit-exactly and in order.

Source files
------------

// File: rtl/typed_stream_fifo.sv
// typed_stream_fifo: show-ahead valid/ready FIFO whose payload is a type parameter,
// exporting the elaboration-time type(T) == type(CHECK_T) result as type_match.
module typed_stream_fifo #(
  parameter type T = logic [7:0],
  parameter type CHECK_T = T,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  T              in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output T              out_data,
  output logic [CW-1:0] count,
  output logic          type_match
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam bit MATCH = type(T) == type(CHECK_T);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("typed_stream_fifo: DEPTH must be a power of two >= 2");
  end
  if ($bits(T) == 0) begin : g_bad_type
    $error("typed_stream_fifo: T must have nonzero width");
  end
  T              mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push, pop;
  // full/empty come from the occupancy counter, so pointers may wrap freely
  assign in_ready   = count != CW'(DEPTH);
  assign out_valid  = count != '0;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_data   = mem[rptr];
  assign type_match = MATCH;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= push ? wptr + AW'(1) : wptr;
      rptr  <= pop ? rptr + AW'(1) : rptr;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wptr] <= in_data;
  end
endmodule
